// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared encodings for the multicycle MIPS controller: opcodes,
//                funct codes, ALU op classes, FSM state codes, control word.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Instruction opcodes
    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_J     = 6'b000010;

    // R-type funct codes
    localparam logic [5:0] C_FN_ADD = 6'b100000;
    localparam logic [5:0] C_FN_SUB = 6'b100010;
    localparam logic [5:0] C_FN_AND = 6'b100100;
    localparam logic [5:0] C_FN_OR  = 6'b100101;
    localparam logic [5:0] C_FN_SLT = 6'b101010;

    // ALU operation classes issued by the FSM
    localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] C_ALUOP_RSVD  = 2'b11;

    // ALU control codes
    localparam logic [2:0] C_ALU_AND = 3'b000;
    localparam logic [2:0] C_ALU_OR  = 3'b001;
    localparam logic [2:0] C_ALU_ADD = 3'b010;
    localparam logic [2:0] C_ALU_SUB = 3'b110;
    localparam logic [2:0] C_ALU_SLT = 3'b111;

    // FSM state encodings
    localparam int         C_STATE_W    = 4;
    localparam logic [3:0] C_ST_FETCH    = 4'd0;
    localparam logic [3:0] C_ST_DECODE   = 4'd1;
    localparam logic [3:0] C_ST_MEMADR   = 4'd2;
    localparam logic [3:0] C_ST_MEMRD    = 4'd3;
    localparam logic [3:0] C_ST_MEMWB    = 4'd4;
    localparam logic [3:0] C_ST_MEMWR    = 4'd5;
    localparam logic [3:0] C_ST_EXECUTE  = 4'd6;
    localparam logic [3:0] C_ST_ALUWB    = 4'd7;
    localparam logic [3:0] C_ST_BRANCH   = 4'd8;
    localparam logic [3:0] C_ST_ADDIEXEC = 4'd9;
    localparam logic [3:0] C_ST_ADDIWB   = 4'd10;
    localparam logic [3:0] C_ST_JUMP     = 4'd11;

    // Raw per-state control word before reset gating and pcen derivation
    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    function automatic logic is_store(input logic [5:0] op);
        return (op == C_OP_SW);
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mc_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : mc_controller_if
//  Description : Datapath <-> controller bundle. master = datapath side,
//                slave = controller side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mc_controller_if;
    import mips_pkg::*;

    logic [5:0]           opcode;
    logic [5:0]           funct;
    logic                 zero;
    logic                 mem_ready;

    logic                 pcen;
    logic                 iord;
    logic                 irwrite;
    logic                 memwrite;
    logic                 regwrite;
    logic                 regdst;
    logic                 memtoreg;
    logic                 alusrca;
    logic [1:0]           alusrcb;
    logic [1:0]           pcsrc;
    logic [2:0]           alu_control;
    logic [C_STATE_W-1:0] state_o;

    modport master (
        output opcode, funct, zero, mem_ready,
        input  pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alu_control, state_o
    );

    modport slave (
        input  opcode, funct, zero, mem_ready,
        output pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alu_control, state_o
    );

endinterface : mc_controller_if
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder
//  Description : Combinational ALU control decode from FSM op class + funct.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = C_ALU_ADD;
        case (i_aluop)
            C_ALUOP_ADD: o_alu_control = C_ALU_ADD;
            C_ALUOP_SUB: o_alu_control = C_ALU_SUB;
            C_ALUOP_FUNCT: begin
                case (i_funct)
                    C_FN_ADD: o_alu_control = C_ALU_ADD;
                    C_FN_SUB: o_alu_control = C_ALU_SUB;
                    C_FN_AND: o_alu_control = C_ALU_AND;
                    C_FN_OR:  o_alu_control = C_ALU_OR;
                    C_FN_SLT: o_alu_control = C_ALU_SLT;
                    default:  o_alu_control = C_ALU_ADD;
                endcase
            end
            // Reserved class falls back to add
            default: o_alu_control = C_ALU_ADD;
        endcase
    end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mc_controller
//  Description : Moore FSM sequencing a multicycle MIPS datapath
//                (lw, sw, R-type, beq, addi, j) with memory stall support.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_controller
    import mips_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    mc_controller_if.slave bus
);

    logic [C_STATE_W-1:0] r_state;
    logic [C_STATE_W-1:0] w_next_state;
    ctrl_t                w_ctrl;
    logic [2:0]           w_alu_control;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= C_ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin : p_next_state
        w_next_state = C_ST_FETCH;
        case (r_state)
            C_ST_FETCH:    w_next_state = bus.mem_ready ? C_ST_DECODE : C_ST_FETCH;
            C_ST_DECODE: begin
                case (bus.opcode)
                    C_OP_LW,
                    C_OP_SW:    w_next_state = C_ST_MEMADR;
                    C_OP_RTYPE: w_next_state = C_ST_EXECUTE;
                    C_OP_BEQ:   w_next_state = C_ST_BRANCH;
                    C_OP_ADDI:  w_next_state = C_ST_ADDIEXEC;
                    C_OP_J:     w_next_state = C_ST_JUMP;
                    default:    w_next_state = C_ST_FETCH;
                endcase
            end
            C_ST_MEMADR:   w_next_state = is_store(bus.opcode) ? C_ST_MEMWR : C_ST_MEMRD;
            C_ST_MEMRD:    w_next_state = bus.mem_ready ? C_ST_MEMWB : C_ST_MEMRD;
            C_ST_MEMWB:    w_next_state = C_ST_FETCH;
            C_ST_MEMWR:    w_next_state = bus.mem_ready ? C_ST_FETCH : C_ST_MEMWR;
            C_ST_EXECUTE:  w_next_state = C_ST_ALUWB;
            C_ST_ALUWB:    w_next_state = C_ST_FETCH;
            C_ST_BRANCH:   w_next_state = C_ST_FETCH;
            C_ST_ADDIEXEC: w_next_state = C_ST_ADDIWB;
            C_ST_ADDIWB:   w_next_state = C_ST_FETCH;
            C_ST_JUMP:     w_next_state = C_ST_FETCH;
            // Unused encodings recover to FETCH
            default:       w_next_state = C_ST_FETCH;
        endcase
    end

    always_comb begin : p_outputs
        w_ctrl       = '0;
        w_ctrl.aluop = C_ALUOP_ADD;
        case (r_state)
            C_ST_FETCH: begin
                w_ctrl.alusrcb = 2'b01;
                w_ctrl.irwrite = bus.mem_ready;
                w_ctrl.pcwrite = bus.mem_ready;
            end
            C_ST_DECODE: begin
                w_ctrl.alusrcb = 2'b11;
            end
            C_ST_MEMADR: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = 2'b10;
            end
            C_ST_MEMRD: begin
                w_ctrl.iord = 1'b1;
            end
            C_ST_MEMWB: begin
                w_ctrl.memtoreg = 1'b1;
                w_ctrl.regwrite = 1'b1;
            end
            C_ST_MEMWR: begin
                w_ctrl.iord     = 1'b1;
                w_ctrl.memwrite = 1'b1;
            end
            C_ST_EXECUTE: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.aluop   = C_ALUOP_FUNCT;
            end
            C_ST_ALUWB: begin
                w_ctrl.regdst   = 1'b1;
                w_ctrl.regwrite = 1'b1;
            end
            C_ST_BRANCH: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.aluop   = C_ALUOP_SUB;
                w_ctrl.pcsrc   = 2'b01;
                w_ctrl.branch  = 1'b1;
            end
            C_ST_ADDIEXEC: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = 2'b10;
            end
            C_ST_ADDIWB: begin
                w_ctrl.regwrite = 1'b1;
            end
            C_ST_JUMP: begin
                w_ctrl.pcsrc   = 2'b10;
                w_ctrl.pcwrite = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_aluop       (w_ctrl.aluop),
        .i_funct       (bus.funct),
        .o_alu_control (w_alu_control)
    );

    // Enables are masked by reset directly so nothing is written while held
    assign bus.pcen        = ~reset & (w_ctrl.pcwrite | (w_ctrl.branch & bus.zero));
    assign bus.irwrite     = ~reset & w_ctrl.irwrite;
    assign bus.memwrite    = ~reset & w_ctrl.memwrite;
    assign bus.regwrite    = ~reset & w_ctrl.regwrite;
    assign bus.iord        = w_ctrl.iord;
    assign bus.regdst      = w_ctrl.regdst;
    assign bus.memtoreg    = w_ctrl.memtoreg;
    assign bus.alusrca     = w_ctrl.alusrca;
    assign bus.alusrcb     = w_ctrl.alusrcb;
    assign bus.pcsrc       = w_ctrl.pcsrc;
    assign bus.alu_control = w_alu_control;
    assign bus.state_o     = r_state;

endmodule : mc_controller
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_controller
//  Description : Self-checking bench: instruction-level model plus literal
//                expectations for the multicycle MIPS controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_controller;
    import mips_pkg::*;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alu;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   m_idx;
    logic cmp_en;

    logic [3:0] rec_state [32];
    exp_t       rec_out   [32];
    int         rec_len;

    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of cycles an instruction occupies with no stalls
    function automatic int prog_len(input logic [5:0] op);
        case (op)
            C_OP_LW:                       return 5;
            C_OP_SW, C_OP_RTYPE, C_OP_ADDI: return 4;
            C_OP_BEQ, C_OP_J:              return 3;
            default:                       return 2;
        endcase
    endfunction

    function automatic logic [3:0] step_state(input logic [5:0] op, input int i);
        if (i == 0) return C_ST_FETCH;
        if (i == 1) return C_ST_DECODE;
        case (op)
            C_OP_LW:    return (i == 2) ? C_ST_MEMADR : (i == 3) ? C_ST_MEMRD : C_ST_MEMWB;
            C_OP_SW:    return (i == 2) ? C_ST_MEMADR : C_ST_MEMWR;
            C_OP_RTYPE: return (i == 2) ? C_ST_EXECUTE : C_ST_ALUWB;
            C_OP_BEQ:   return C_ST_BRANCH;
            C_OP_ADDI:  return (i == 2) ? C_ST_ADDIEXEC : C_ST_ADDIWB;
            C_OP_J:     return C_ST_JUMP;
            default:    return C_ST_FETCH;
        endcase
    endfunction

    function automatic logic waits_on_mem(input logic [3:0] st);
        return (st == C_ST_FETCH) || (st == C_ST_MEMRD) || (st == C_ST_MEMWR);
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic exp_t expect_out(input logic [3:0] st, input logic mr,
                                        input logic z, input logic [5:0] fn,
                                        input logic rst);
        exp_t       e;
        logic       pcw;
        logic       br;
        logic [1:0] aop;
        e   = '0;
        pcw = 1'b0;
        br  = 1'b0;
        aop = 2'b00;
        case (st)
            C_ST_FETCH:    begin e.alusrcb = 2'b01; e.irwrite = mr; pcw = mr; end
            C_ST_DECODE:   e.alusrcb = 2'b11;
            C_ST_MEMADR:   begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            C_ST_MEMRD:    e.iord = 1'b1;
            C_ST_MEMWB:    begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            C_ST_MEMWR:    begin e.iord = 1'b1; e.memwrite = 1'b1; end
            C_ST_EXECUTE:  begin e.alusrca = 1'b1; aop = 2'b10; end
            C_ST_ALUWB:    begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            C_ST_BRANCH:   begin e.alusrca = 1'b1; aop = 2'b01; e.pcsrc = 2'b01; br = 1'b1; end
            C_ST_ADDIEXEC: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            C_ST_ADDIWB:   e.regwrite = 1'b1;
            C_ST_JUMP:     begin e.pcsrc = 2'b10; pcw = 1'b1; end
            default:       e = '0;
        endcase
        e.pcen = pcw | (br & z);
        e.alu  = (aop == 2'b10) ? funct_alu(fn) : (aop == 2'b01) ? 3'b110 : 3'b010;
        if (rst) begin
            e.irwrite  = 1'b0;
            e.pcen     = 1'b0;
            e.memwrite = 1'b0;
            e.regwrite = 1'b0;
        end
        return e;
    endfunction

    function automatic exp_t dut_out();
        exp_t a;
        a = {bus.pcen, bus.iord, bus.irwrite, bus.memwrite, bus.regwrite,
             bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb, bus.pcsrc,
             bus.alu_control};
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Instruction-level model: position within the current instruction
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_idx <= 0;
        end else if (waits_on_mem(step_state(bus.opcode, m_idx)) && !bus.mem_ready) begin
            m_idx <= m_idx;
        end else if (m_idx + 1 >= prog_len(bus.opcode)) begin
            m_idx <= 0;
        end else begin
            m_idx <= m_idx + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [3:0] es;
            exp_t       e;
            es = reset ? C_ST_FETCH : step_state(bus.opcode, m_idx);
            e  = expect_out(es, bus.mem_ready, bus.zero, bus.funct, reset);
            chk("model_state", 32'(bus.state_o), 32'(es));
            chk("model_outputs", 32'(dut_out()), 32'(e));
        end
    end

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fetch_stalls, input int mem_stalls);
        int n;
        n = 0;
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        for (int i = 0; i < prog_len(op); i++) begin
            logic [3:0] st;
            int         stalls;
            st     = step_state(op, i);
            stalls = (i == 0) ? fetch_stalls : (waits_on_mem(st) ? mem_stalls : 0);
            for (int k = 0; k <= stalls; k++) begin
                bus.mem_ready = (k == stalls);
                @(negedge clk);
                if (n < 32) begin
                    rec_state[n] = bus.state_o;
                    rec_out[n]   = dut_out();
                end
                n++;
                @(posedge clk);
                #1;
            end
        end
        rec_len = n;
    endtask

    logic [3:0] lw_seq [5];
    int         mw_cnt;
    int         wr_cnt;

    initial begin
        checks        = 0;
        errors        = 0;
        cmp_en        = 1'b0;
        reset         = 1'b1;
        bus.opcode    = 6'b0;
        bus.funct     = 6'b0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        lw_seq = '{C_ST_FETCH, C_ST_DECODE, C_ST_MEMADR, C_ST_MEMRD, C_ST_MEMWB};
        #1 cmp_en = 1'b1;

        // Reset state: FETCH decode with enables forced low
        @(negedge clk); #1;
        chk("reset_state", 32'(bus.state_o), 32'(C_ST_FETCH));
        chk("reset_irwrite", 32'(bus.irwrite), 32'd0);
        chk("reset_pcen", 32'(bus.pcen), 32'd0);
        chk("reset_alusrcb", 32'(bus.alusrcb), 32'd1);
        bus.mem_ready = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        // lw, no stalls
        run_instr(C_OP_LW, 6'b0, 1'b0, 0, 0);
        chk("lw_len", 32'(rec_len), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("lw_state", 32'(rec_state[i]), 32'(lw_seq[i]));
            chk("lw_regwrite", 32'(rec_out[i].regwrite), 32'(i == 4));
            chk("lw_memtoreg", 32'(rec_out[i].memtoreg), 32'(i == 4));
        end

        // beq taken / not taken
        run_instr(C_OP_BEQ, 6'b0, 1'b1, 0, 0);
        chk("beq_len", 32'(rec_len), 32'd3);
        chk("beq_state", 32'(rec_state[2]), 32'(C_ST_BRANCH));
        chk("beq_taken_pcen", 32'(rec_out[2].pcen), 32'd1);
        chk("beq_alu", 32'(rec_out[2].alu), 32'b110);
        run_instr(C_OP_BEQ, 6'b0, 1'b0, 0, 0);
        chk("beq_nottaken_pcen", 32'(rec_out[2].pcen), 32'd0);

        // R-type slt and and
        run_instr(C_OP_RTYPE, C_FN_SLT, 1'b0, 0, 0);
        chk("rt_len", 32'(rec_len), 32'd4);
        chk("slt_state", 32'(rec_state[2]), 32'(C_ST_EXECUTE));
        chk("slt_alu", 32'(rec_out[2].alu), 32'b111);
        chk("aluwb_regdst", 32'(rec_out[3].regdst), 32'd1);
        run_instr(C_OP_RTYPE, C_FN_AND, 1'b0, 0, 0);
        chk("and_alu", 32'(rec_out[2].alu), 32'b000);

        // j with three stalled fetch cycles
        run_instr(C_OP_J, 6'b0, 1'b0, 3, 0);
        chk("j_len", 32'(rec_len), 32'd6);
        for (int i = 0; i < 3; i++) begin
            chk("stall_irwrite", 32'(rec_out[i].irwrite), 32'd0);
            chk("stall_pcen", 32'(rec_out[i].pcen), 32'd0);
        end
        chk("fetch_irwrite", 32'(rec_out[3].irwrite), 32'd1);
        chk("j_pcsrc", 32'(rec_out[5].pcsrc), 32'b10);
        chk("j_pcen", 32'(rec_out[5].pcen), 32'd1);

        // sw with MEMWR stalled two cycles
        run_instr(C_OP_SW, 6'b0, 1'b0, 0, 2);
        chk("sw_len", 32'(rec_len), 32'd6);
        mw_cnt = 0;
        for (int i = 0; i < rec_len && i < 32; i++) mw_cnt += int'(rec_out[i].memwrite);
        chk("sw_memwrite_cycles", 32'(mw_cnt), 32'd3);

        // addi
        run_instr(C_OP_ADDI, 6'b0, 1'b0, 0, 0);
        chk("addi_len", 32'(rec_len), 32'd4);
        chk("addiwb_state", 32'(rec_state[3]), 32'(C_ST_ADDIWB));
        chk("addiwb_regwrite", 32'(rec_out[3].regwrite), 32'd1);

        // Unknown opcode returns to FETCH with no writes
        run_instr(6'b111111, 6'b0, 1'b0, 0, 0);
        chk("unk_len", 32'(rec_len), 32'd2);
        wr_cnt = 0;
        for (int i = 0; i < 2; i++) wr_cnt += int'(rec_out[i].regwrite) + int'(rec_out[i].memwrite);
        chk("unk_writes", 32'(wr_cnt), 32'd0);
        chk("unk_back_fetch", 32'(bus.state_o), 32'(C_ST_FETCH));

        // Reset asserted during MEMWB of a lw
        bus.opcode    = C_OP_LW;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("pre_rst_state", 32'(bus.state_o), 32'(C_ST_MEMWB));
        chk("pre_rst_regwrite", 32'(bus.regwrite), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_state", 32'(bus.state_o), 32'(C_ST_FETCH));
        chk("async_rst_regwrite", 32'(bus.regwrite), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("rst_hold_irwrite", 32'(bus.irwrite), 32'd0);
        chk("rst_hold_pcen", 32'(bus.pcen), 32'd0);
        bus.mem_ready = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        // Recovery after reset
        run_instr(C_OP_RTYPE, C_FN_ADD, 1'b0, 0, 0);
        chk("post_rst_add_alu", 32'(rec_out[2].alu), 32'b010);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mc_controller
`default_nettype wire

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have no parameters; all encodings come from the shared package.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  instruction opcode from instruction register.
REQ-005 funct  input  6  instruction funct field.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory access completes this cycle.
REQ-008 pcen  output  1  PC register enable.
REQ-009 iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca  output  1 each  datapath selects and enables.
REQ-010 alusrcb  output  2  ALU B-operand mux select.
REQ-011 pcsrc  output  2  next-PC mux select.
REQ-012 alu_control  output  3  ALU operation code.
REQ-013 state_o  output  4  current state, for debug and bench.

Function
REQ-014 The block SHALL be a Moore FSM sequencing a multicycle MIPS datapath for lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000 and j 000010.
REQ-015 The states SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB and JUMP.
REQ-016 FETCH SHALL drive iord=0, alusrca=0, alusrcb=01 and aluop=00.
- irwrite=1 and pcwrite=1 only when mem_ready=1.
- The FSM holds in FETCH while mem_ready=0 and goes to DECODE when mem_ready=1.
REQ-017 DECODE SHALL drive alusrcb=11 and aluop=00, then go to:
- MEMADR for lw or sw;
- EXECUTE for R-type;
- BRANCH for beq;
- ADDIEXEC for addi;
- JUMP for j;
- FETCH for any other opcode, with no write enable asserted.
REQ-018 MEMADR SHALL drive alusrca=1, alusrcb=10 and aluop=00, then go to MEMRD for lw or MEMWR for sw.
REQ-019 MEMRD SHALL drive iord=1, hold while mem_ready=0, and go to MEMWB when mem_ready=1.
REQ-020 MEMWB SHALL drive regdst=0, memtoreg=1 and regwrite=1, then go to FETCH.
REQ-021 MEMWR SHALL drive iord=1 and memwrite=1, hold while mem_ready=0, and go to FETCH when mem_ready=1.
REQ-022 EXECUTE SHALL drive alusrca=1, alusrcb=00 and aluop=10, then go to ALUWB.
REQ-023 ALUWB SHALL drive regdst=1, memtoreg=0 and regwrite=1, then go to FETCH.
REQ-024 BRANCH SHALL drive alusrca=1, alusrcb=00, aluop=01, pcsrc=01 and branch=1, then go to FETCH.
REQ-025 ADDIEXEC SHALL drive alusrca=1, alusrcb=10 and aluop=00, then go to ADDIWB.
REQ-026 ADDIWB SHALL drive regdst=0, memtoreg=0 and regwrite=1, then go to FETCH.
REQ-027 JUMP SHALL drive pcsrc=10 and pcwrite=1, then go to FETCH.
REQ-028 Outputs not listed for a state SHALL be 0.
REQ-029 pcen SHALL equal pcwrite | (branch & zero), combinationally within the cycle.
REQ-030 alu_control SHALL decode as follows:
- aluop 00 gives 010; aluop 01 gives 110.
- aluop 10 with funct 100000/100010/100100/100101/101010 gives 010/110/000/001/111; any other funct gives 010.
- aluop 11 gives 010.
REQ-031 Instruction latency SHALL be 3 cycles for beq and j, 4 for R-type, addi and sw, and 5 for lw, each with mem_ready=1 throughout, plus one cycle per stalled memory cycle.

Reset
REQ-032 Reset SHALL force state FETCH asynchronously, taking effect mid-instruction without completing the pending write.
REQ-033 While reset=1, memwrite, regwrite, irwrite and pcen SHALL be 0; after deassertion outputs follow the FETCH decode.
REQ-034 Illegal state encodings SHALL return to FETCH on the next edge.

Structure
REQ-035 Opcode constants, funct constants, state encodings and aluop codes SHALL live in a shared package, mips_pkg.
REQ-036 The alu_control decode SHALL be a combinational sub-module, alu_decoder, instantiated once.

Verification
REQ-037 lw, mem_ready=1: after reset, opcode=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-038 beq, opcode=000100: zero=1 -> pcen=1 in the BRANCH cycle; zero=0 -> pcen=0.
REQ-039 R-type, opcode=000000: funct=101010 -> alu_control=111 in EXECUTE; funct=100100 -> 000.
REQ-040 Stalls: mem_ready=0 for 3 cycles in FETCH -> irwrite=0 and pcen=0 for those cycles; sw with MEMWR stalled 2 cycles keeps memwrite=1 for 3 cycles.
REQ-041 Reset mid-instruction: assert reset during MEMWB -> state_o=FETCH immediately and regwrite=0 without waiting for a clock edge.
REQ-042 Unknown opcode=111111 -> DECODE returns to FETCH with no regwrite or memwrite pulse.
